// File: rtl/hwag_pkg.sv
// Shared types and constants for the angle generator and channel scheduler.
package hwag_pkg;

  localparam int ANGLE_WIDTH = 24;
  localparam int ANGLE_TOP   = 3839;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } sched_state_t;

  typedef enum logic {
    CFG_SET   = 1'b0,
    CFG_RESET = 1'b1
  } cfg_sel_t;

endpackage

// File: rtl/hwag_chan_sched_if.sv
// Configuration write bus for the channel scheduler (valid/ready handshake).
interface hwag_chan_sched_if #(
  parameter int CH_NUM      = 4,
  parameter int ANGLE_WIDTH = hwag_pkg::ANGLE_WIDTH
);
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [$clog2(CH_NUM)-1:0]  cfg_ch;
  logic                       cfg_sel;
  logic [ANGLE_WIDTH-1:0]     cfg_data;

  modport master (
    output cfg_valid, cfg_ch, cfg_sel, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_sel, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/hwag_chan_regs.sv
// Per-channel set/reset angle registers with write decode and read mux.
// HWAG_SCHED_SHADOW_EN adds shadow registers copied to active on i_commit.
module hwag_chan_regs #(
  parameter int CH_NUM      = 4,
  parameter int ANGLE_WIDTH = hwag_pkg::ANGLE_WIDTH,
  parameter int ANGLE_TOP   = hwag_pkg::ANGLE_TOP,
  localparam int CW         = $clog2(CH_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [CW-1:0]          i_wr_ch,
  input  logic                   i_wr_sel,
  input  logic [ANGLE_WIDTH-1:0] i_wr_data,
`ifdef HWAG_SCHED_SHADOW_EN
  input  logic                   i_commit,
`endif
  input  logic [CW-1:0]          i_rd_ch,
  output logic [ANGLE_WIDTH-1:0] o_set_angle,
  output logic [ANGLE_WIDTH-1:0] o_reset_angle
);
  import hwag_pkg::*;

  // One past the last angle: a value the comparator can never accept.
  localparam logic [ANGLE_WIDTH-1:0] LP_NEVER = ANGLE_WIDTH'(ANGLE_TOP + 1);

  logic [ANGLE_WIDTH-1:0] r_set_angle   [CH_NUM];
  logic [ANGLE_WIDTH-1:0] r_reset_angle [CH_NUM];

`ifdef HWAG_SCHED_SHADOW_EN
  logic [ANGLE_WIDTH-1:0] r_sh_set_angle   [CH_NUM];
  logic [ANGLE_WIDTH-1:0] r_sh_reset_angle [CH_NUM];

  // Commit copies the old shadow; a same-cycle write lands in shadow only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < unsigned'(CH_NUM); k++) begin
        r_set_angle[k]      <= LP_NEVER;
        r_reset_angle[k]    <= LP_NEVER;
        r_sh_set_angle[k]   <= LP_NEVER;
        r_sh_reset_angle[k] <= LP_NEVER;
      end
    end else begin
      if (i_wr_en) begin
        if (cfg_sel_t'(i_wr_sel) == CFG_RESET) r_sh_reset_angle[i_wr_ch] <= i_wr_data;
        else                                   r_sh_set_angle[i_wr_ch]   <= i_wr_data;
      end
      if (i_commit) begin
        for (int unsigned k = 0; k < unsigned'(CH_NUM); k++) begin
          r_set_angle[k]   <= r_sh_set_angle[k];
          r_reset_angle[k] <= r_sh_reset_angle[k];
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < unsigned'(CH_NUM); k++) begin
        r_set_angle[k]   <= LP_NEVER;
        r_reset_angle[k] <= LP_NEVER;
      end
    end else if (i_wr_en) begin
      if (cfg_sel_t'(i_wr_sel) == CFG_RESET) r_reset_angle[i_wr_ch] <= i_wr_data;
      else                                   r_set_angle[i_wr_ch]   <= i_wr_data;
    end
  end
`endif

  assign o_set_angle   = r_set_angle[i_rd_ch];
  assign o_reset_angle = r_reset_angle[i_rd_ch];

endmodule

// File: rtl/hwag_chan_sched.sv
// Angle-step driven channel scheduler: one shared comparator pair scans channels serially.
// HWAG_SCHED_SHADOW_EN selects shadowed configuration committed at angle 0.
module hwag_chan_sched #(
  parameter int CH_NUM      = 4,
  parameter int ANGLE_WIDTH = hwag_pkg::ANGLE_WIDTH,
  parameter int ANGLE_TOP   = hwag_pkg::ANGLE_TOP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [ANGLE_WIDTH-1:0] acnt,
  hwag_chan_sched_if.slave       cfg,
  output logic [CH_NUM-1:0]      ch_out,
  output logic                   overrun
);
  import hwag_pkg::*;

  localparam int CW = $clog2(CH_NUM);
  localparam logic [ANGLE_WIDTH-1:0] LP_TOP  = ANGLE_WIDTH'(ANGLE_TOP);
  localparam logic [CW-1:0]          LP_LAST = CW'(CH_NUM - 1);

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  logic [ANGLE_WIDTH-1:0] r_acnt_q;
  logic                   r_start_q;
  logic [CW-1:0]          r_ch_idx;
  logic [CW-1:0]          w_idx_nxt;
  logic [ANGLE_WIDTH-1:0] r_scan_angle;
  logic [ANGLE_WIDTH-1:0] w_scan_nxt;
  logic [ANGLE_WIDTH-1:0] r_pend_angle;
  logic [ANGLE_WIDTH-1:0] w_pend_nxt;
  logic                   r_step_pend;
  logic                   w_pend_flag_nxt;
  logic                   w_ovr_set;
  logic [CH_NUM-1:0]      r_ch_out;
  logic                   r_overrun;

  logic                   w_step;
  logic                   w_last;
  logic                   w_cfg_ready;
  logic                   w_wr_en;
  logic [ANGLE_WIDTH-1:0] w_set_angle;
  logic [ANGLE_WIDTH-1:0] w_reset_angle;
  logic                   w_in_range;
  logic                   w_set_hit;
  logic                   w_reset_hit;

  assign w_step = hwag_start && ((acnt != r_acnt_q) || !r_start_q);
  assign w_last = (r_ch_idx == LP_LAST);

`ifdef HWAG_SCHED_SHADOW_EN
  logic w_commit;
  // Scan of angle 0 is about to start (entry or rescan): publish shadow now.
  assign w_commit    = (w_state_nxt == ST_SCAN) && (w_idx_nxt == '0) && (w_scan_nxt == '0);
  assign w_cfg_ready = !rst;
`else
  assign w_cfg_ready = !rst && (r_state == ST_IDLE) && !w_step;
`endif

  assign cfg.cfg_ready = w_cfg_ready;
  assign w_wr_en       = cfg.cfg_valid && w_cfg_ready;

  hwag_chan_regs #(
    .CH_NUM      (CH_NUM),
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ANGLE_TOP   (ANGLE_TOP)
  ) u_regs (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (w_wr_en),
    .i_wr_ch       (cfg.cfg_ch),
    .i_wr_sel      (cfg.cfg_sel),
    .i_wr_data     (cfg.cfg_data),
`ifdef HWAG_SCHED_SHADOW_EN
    .i_commit      (w_commit),
`endif
    .i_rd_ch       (r_ch_idx),
    .o_set_angle   (w_set_angle),
    .o_reset_angle (w_reset_angle)
  );

  assign w_in_range  = (r_scan_angle <= LP_TOP);
  assign w_set_hit   = w_in_range && (r_scan_angle == w_set_angle);
  assign w_reset_hit = w_in_range && (r_scan_angle == w_reset_angle);

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_ch_idx;
    w_scan_nxt      = r_scan_angle;
    w_pend_nxt      = r_pend_angle;
    w_pend_flag_nxt = r_step_pend;
    w_ovr_set       = 1'b0;
    if (!hwag_start) begin
      w_state_nxt     = ST_IDLE;
      w_idx_nxt       = '0;
      w_pend_flag_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_step) begin
            w_state_nxt = ST_SCAN;
            w_scan_nxt  = acnt;
            w_idx_nxt   = '0;
          end
        end
        ST_SCAN: begin
          w_idx_nxt = r_ch_idx + CW'(1);
          if (w_step) begin
            w_pend_nxt      = acnt;
            w_pend_flag_nxt = 1'b1;
            w_ovr_set       = r_step_pend;
          end
          // A step landing on the last channel is taken straight into the rescan.
          if (w_last) begin
            w_idx_nxt = '0;
            if (w_step) begin
              w_scan_nxt      = acnt;
              w_pend_flag_nxt = 1'b0;
            end else if (r_step_pend) begin
              w_scan_nxt      = r_pend_angle;
              w_pend_flag_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_acnt_q     <= '0;
      r_start_q    <= 1'b0;
      r_ch_idx     <= '0;
      r_scan_angle <= '0;
      r_pend_angle <= '0;
      r_step_pend  <= 1'b0;
      r_ch_out     <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acnt_q     <= acnt;
      r_start_q    <= hwag_start;
      r_ch_idx     <= w_idx_nxt;
      r_scan_angle <= w_scan_nxt;
      r_pend_angle <= w_pend_nxt;
      r_step_pend  <= w_pend_flag_nxt;
      r_overrun    <= r_overrun | w_ovr_set;
      if (!hwag_start) begin
        r_ch_out <= '0;
      end else if (r_state == ST_SCAN) begin
        if (w_reset_hit)    r_ch_out[r_ch_idx] <= 1'b0;
        else if (w_set_hit) r_ch_out[r_ch_idx] <= 1'b1;
      end
    end
  end

  assign ch_out  = r_ch_out;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_hwag_chan_sched.sv
// Directed bench for hwag_chan_sched: step table plus hand-timed corner sequences.
module tb_hwag_chan_sched;
  import hwag_pkg::*;

  localparam int CH = 4;
  localparam int AW = 24;

  typedef struct {
    int unsigned    angle;
    logic [CH-1:0]  exp_out;
  } step_vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hwag_start = 1'b0;
  logic [AW-1:0] acnt = '0;
  logic [CH-1:0] ch_out;
  logic          overrun;
  int            n_pass = 0;
  int            n_total = 0;
  step_vec_t     vecs [11];

  hwag_chan_sched_if #(.CH_NUM(CH), .ANGLE_WIDTH(AW)) cfg_if ();

  hwag_chan_sched #(
    .CH_NUM      (CH),
    .ANGLE_WIDTH (AW),
    .ANGLE_TOP   (3839)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .acnt       (acnt),
    .cfg        (cfg_if),
    .ch_out     (ch_out),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step_to(input int unsigned a);
    acnt = AW'(a);
    repeat (6) tick();
  endtask

  task automatic cfg_write(input int unsigned ch, input logic sel, input int unsigned data);
    int n;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_sel   = sel;
    cfg_if.cfg_data  = AW'(data);
    #1;
    n = 0;
    while (!cfg_if.cfg_ready && n < 20) begin
      tick();
      n++;
    end
    check("cfg_accept", 32'(cfg_if.cfg_ready), 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = '{0,    4'b0000};
    vecs[1]  = '{5,    4'b0100};
    vecs[2]  = '{10,   4'b0101};
    vecs[3]  = '{20,   4'b0100};
    vecs[4]  = '{100,  4'b0110};
    vecs[5]  = '{200,  4'b0100};
    vecs[6]  = '{3839, 4'b1100};
    vecs[7]  = '{3840, 4'b1100};
    vecs[8]  = '{4000, 4'b1100};
    vecs[9]  = '{0,    4'b1100};
    vecs[10] = '{10,   4'b1101};

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_sel   = 1'b0;
    cfg_if.cfg_data  = '0;

    repeat (2) tick();
    check("rst_ch_out", 32'(ch_out), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    tick();
    check("ready_idle", 32'(cfg_if.cfg_ready), 1);

    cfg_write(0, CFG_SET, 10);
    cfg_write(0, CFG_RESET, 20);
    cfg_write(1, CFG_SET, 100);
    cfg_write(1, CFG_RESET, 200);
    cfg_write(2, CFG_SET, 5);
    cfg_write(2, CFG_RESET, 4000);
    cfg_write(3, CFG_SET, 3839);

    hwag_start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step_to(vecs[i].angle);
      check($sformatf("step%0d_out", i), 32'(ch_out), 32'(vecs[i].exp_out));
      check($sformatf("step%0d_ovr", i), 32'(overrun), 0);
    end

    // Exact rise/fall latency on channel 1
    step_to(99);
    acnt = AW'(100);
    tick(); check("rise_d1", 32'(ch_out[1]), 0);
    tick(); check("rise_d2", 32'(ch_out[1]), 0);
    tick(); check("rise_d3", 32'(ch_out[1]), 1);
    repeat (3) tick();
    step_to(199);
    acnt = AW'(200);
    repeat (2) tick(); check("fall_d2", 32'(ch_out[1]), 1);
    tick();            check("fall_d3", 32'(ch_out[1]), 0);
    repeat (3) tick();

    // Set and reset on the same angle: reset wins
    cfg_write(0, CFG_SET, 50);
    cfg_write(0, CFG_RESET, 50);
    step_to(0);
    check("pre_both_ch0", 32'(ch_out[0]), 1);
    acnt = AW'(50);
    tick(); check("both_d1", 32'(ch_out[0]), 1);
    tick(); check("both_d2", 32'(ch_out[0]), 0);
    repeat (4) tick();
    check("both_out", 32'(ch_out), 32'(4'b1100));

    // Three steps on consecutive cycles: the middle one is lost
    cfg_write(0, CFG_SET, 11);
    cfg_write(1, CFG_SET, 12);
    step_to(0);
    acnt = AW'(10); tick();
    acnt = AW'(11); tick();
    acnt = AW'(12); tick();
    check("ovr_set", 32'(overrun), 1);
    repeat (3) tick(); check("ovr_rescan_d6", 32'(ch_out[1]), 0);
    tick();            check("ovr_rescan_d7", 32'(ch_out[1]), 1);
    repeat (6) tick();
    check("ovr_out", 32'(ch_out), 32'(4'b1110));
    check("ovr_sticky", 32'(overrun), 1);

    // hwag_start drop mid-scan
    acnt = AW'(13);
    repeat (2) tick();
    hwag_start = 1'b0;
    tick();
    check("drop_out", 32'(ch_out), 0);
    check("drop_ready", 32'(cfg_if.cfg_ready), 1);
    hwag_start = 1'b1;
    step_to(12);
    check("drop_cfg_kept", 32'(ch_out), 32'(4'b0010));
    check("drop_ovr_kept", 32'(overrun), 1);

`ifdef HWAG_SCHED_SHADOW_EN
    step_to(3000);
    cfg_write(2, CFG_SET, 7);
    acnt = AW'(7);
    tick();
    check("sh_ready_scan", 32'(cfg_if.cfg_ready), 1);
    repeat (5) tick();
    check("sh_before_wrap", 32'(ch_out), 32'(4'b0010));
    step_to(3839);
    check("sh_at_top", 32'(ch_out), 32'(4'b1010));
    step_to(0);
    check("sh_commit", 32'(ch_out), 32'(4'b1010));
    step_to(7);
    check("sh_after_wrap", 32'(ch_out), 32'(4'b1110));
`else
    acnt = AW'(14);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd1;
    cfg_if.cfg_sel   = CFG_RESET;
    cfg_if.cfg_data  = AW'(15);
    #1;
    check("ready_in_detect", 32'(cfg_if.cfg_ready), 0);
    n = 0;
    while (!cfg_if.cfg_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait_cycles", 32'(n), 5);
    tick();
    cfg_if.cfg_valid = 1'b0;
    step_to(15);
    check("held_write_applied", 32'(ch_out), 0);
`endif

    // Reset in the middle of a scan with a write pending
    acnt = AW'(16);
    repeat (2) tick();
    rst = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd3;
    cfg_if.cfg_sel   = CFG_SET;
    cfg_if.cfg_data  = AW'(16);
    tick();
    check("midrst_out", 32'(ch_out), 0);
    check("midrst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    hwag_start = 1'b0;
    acnt = '0;
    tick();
    check("midrst_ready", 32'(cfg_if.cfg_ready), 1);
    hwag_start = 1'b1;
    step_to(0);
    check("midrst_a0", 32'(ch_out), 0);
    step_to(16);
    check("midrst_wr_dropped", 32'(ch_out), 0);
    step_to(12);
    check("midrst_cfg_cleared", 32'(ch_out), 0);
    check("midrst_ovr_end", 32'(overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
